dpb_port_arbiter: RTL
=====================

# dpb_port_arbiter

Two-requester arbiter and access sequencer for port A of the 8k×8 Gowin dual-port block RAM (`Gowin_DPB_8k`, bypass read mode). It accepts single-byte read/write requests from two independent masters, grants them round-robin, and generates the full clka/cea/ocea/wrea/ada/dina sequence from `sysclk`. It replaces hand-written per-access state sequencing in the top level. The RAM clock is derived from `sysclk` by the arbiter, never driven directly.

## Interface
Parameters:
- `ADDR_W`, 13, RAM address width
- `DATA_W`, 8, RAM data width
- `CLK_HALF`, 1, sysclk cycles per clka half-phase (≥1)

Ports:
- `sysclk`  in  1  system clock; all state changes on its rising edge
- `external_reset`  in  1  asynchronous, active-high reset
- `req0` / `req1`  in  1  access request, held until matching ack
- `we0` / `we1`  in  1  1 = write, 0 = read; valid while req high
- `addr0` / `addr1`  in  ADDR_W  byte address
- `wdata0` / `wdata1`  in  DATA_W  write data
- `ack0` / `ack1`  out  1  one-cycle completion pulse
- `rdata0` / `rdata1`  out  DATA_W  last read result for that requester, held
- `busy`  out  1  high whenever state ≠ IDLE
- `mem_clka`, `mem_cea`, `mem_ocea`, `mem_wrea`, `mem_reseta`  out  1  RAM port A controls
- `mem_ada`  out  ADDR_W;  `mem_dina`  out  DATA_W
- `mem_douta`  in  DATA_W  RAM port A read data

## Operation
- States: IDLE → SETUP → HIGH → LOW → ACK → IDLE.
- IDLE: if any req is high, choose a grant, latch its we/addr/wdata into `mem_wrea`/`mem_ada`/`mem_dina`, set cea = ocea = 1, keep clka = 0, and go to SETUP.
- SETUP: 1 cycle with clka = 0, giving address/data setup.
- HIGH: clka = 1 for CLK_HALF cycles, counted by a half-phase counter.
- LOW: clka = 0 and cea/ocea/wrea = 0 for CLK_HALF cycles.
- On exit from LOW into ACK: for a read, the granted `rdataN` ← `mem_douta`; for a write, rdata is unchanged.
- ACK: `ackN` = 1 for exactly one cycle, then IDLE.
- Round-robin: a `last` bit records the last-served requester.
  - If both req are high in IDLE, grant the requester ≠ `last`.
  - If only one is high, grant it.
  - `last` updates in ACK.
- `mem_reseta` is constant 0. `mem_ada`/`mem_dina` hold their last value between accesses.
- Request inputs are sampled only in IDLE. Changes to addr/we/wdata after the grant are ignored.
- If req drops mid-access, the access still completes and ack still pulses.
- A req still high in IDLE after its ack counts as a new request.
- Reset, asynchronous at any point:
  - state = IDLE, `last` = 1 (req0 wins first contention)
  - all mem_* outputs = 0, ack0/ack1 = 0, busy = 0, rdata0/rdata1 = 0
  - An in-flight write may or may not have landed; no ack is issued for it.

## Timing
- Let req be seen in IDLE at edge E0. With H = CLK_HALF:
  - clka rises at E0+1, falls at E0+1+H
  - rdata updates and ack rises at E0+1+2H
  - ack falls and IDLE is re-entered at E0+2+2H
- H = 1: ack is high in the cycle after E3, giving 5 cycles per access.
- Back-to-back accesses, either requester: the next grant is taken at E0+3+2H, so the period is 3+2H cycles.
- rdata is stable from the ack cycle until that requester's next read ack.
- `busy` rises at E0 and falls at E0+2+2H.
- Any mem_* output changes at most once per sysclk edge.
- cea, wrea, ada and dina never change on the same edge that clka rises.

## Test plan
- Reset release, req0 write addr 0x0000 data 0xAA, then req0 read 0x0000 → one ack0 pulse each, 5 cycles per access, rdata0 = 0xAA, ack1 never asserted.
- req0 and req1 asserted on the same cycle after reset (req0 write 0x1FFF=0x55, req1 read 0x1FFF) → req0 served first, then req1; rdata1 = 0x55.
- Both req held high continuously for 8 accesses → grants alternate 0,1,0,1…; no starvation; each ack is exactly 1 cycle.
- CLK_HALF = 3, single read → clka high for 3 cycles and low for 3; ack at E0+7; data correct.
- req1 deasserted and addr1 changed during HIGH → access completes at the originally latched address; ack1 still pulses once.
- external_reset asserted during HIGH → clka, cea, wrea, ack and busy go 0 immediately without waiting for an edge; after release, the first contention is granted to req0.

Source files
------------

// File: rtl/dpb_port_arbiter.sv
// dpb_port_arbiter
//
// Round-robin arbiter and access sequencer for port A of an 8k x 8 dual-port
// block RAM that runs in bypass read mode. Two masters issue single-byte
// read/write requests. Each granted access is turned into a complete
// clka/cea/ocea/wrea/ada/dina sequence. The RAM clock is generated here from
// sysclk.
//
// Ports:
//   sysclk, external_reset   system clock; asynchronous active-high reset
//   req0/1, we0/1            request (held until ack) and write enable
//   addr0/1, wdata0/1        byte address and write data for each requester
//   ack0/1                   one-cycle completion pulse
//   rdata0/1                 last read result for each requester, held
//   busy                     high while an access is in progress
//   mem_clka .. mem_dina     RAM port A controls, address and write data
//   mem_douta                RAM port A read data
module dpb_port_arbiter #(
  parameter int ADDR_W   = 13,
  parameter int DATA_W   = 8,
  parameter int CLK_HALF = 1
) (
  input  logic              sysclk,
  input  logic              external_reset,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack0,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              busy,
  output logic              mem_clka,
  output logic              mem_cea,
  output logic              mem_ocea,
  output logic              mem_wrea,
  output logic              mem_reseta,
  output logic [ADDR_W-1:0] mem_ada,
  output logic [DATA_W-1:0] mem_dina,
  input  logic [DATA_W-1:0] mem_douta
);

  typedef enum logic [2:0] {IDLE, SETUP, HIGH, LOW, ACK} state_t;

  localparam int              CNT_W    = (CLK_HALF > 1) ? $clog2(CLK_HALF) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_HALF - 1);

  state_t              state_reg, state_next;
  logic [CNT_W-1:0]    cnt_reg, cnt_next;
  logic                last_reg, last_next;
  logic                grant_reg, grant_next;
  logic                we_reg, we_next;
  logic                clka_reg, clka_next;
  logic                cea_reg, cea_next;
  logic                wrea_reg, wrea_next;
  logic [ADDR_W-1:0]   ada_reg, ada_next;
  logic [DATA_W-1:0]   dina_reg, dina_next;
  logic                pick;
  logic                half_done;
  logic                capture;

  assign half_done = (cnt_reg == CNT_LAST);
  // Final cycle of LOW: read data is valid and the ack pulse is launched.
  assign capture   = (state_reg == LOW) && half_done;

  always_ff @(posedge sysclk or posedge external_reset) begin
    if (external_reset) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      last_reg  <= 1'b1;  // requester 0 wins the first contention
      grant_reg <= 1'b0;
      we_reg    <= 1'b0;
      clka_reg  <= 1'b0;
      cea_reg   <= 1'b0;
      wrea_reg  <= 1'b0;
      ada_reg   <= '0;
      dina_reg  <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      last_reg  <= last_next;
      grant_reg <= grant_next;
      we_reg    <= we_next;
      clka_reg  <= clka_next;
      cea_reg   <= cea_next;
      wrea_reg  <= wrea_next;
      ada_reg   <= ada_next;
      dina_reg  <= dina_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    last_next  = last_reg;
    grant_next = grant_reg;
    we_next    = we_reg;
    clka_next  = clka_reg;
    cea_next   = cea_reg;
    wrea_next  = wrea_reg;
    ada_next   = ada_reg;
    dina_next  = dina_reg;
    pick       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (req0 || req1) begin
          // Contention goes to the requester not served last time.
          pick       = (req0 && req1) ? ~last_reg : req1;
          grant_next = pick;
          we_next    = pick ? we1 : we0;
          wrea_next  = pick ? we1 : we0;
          ada_next   = pick ? addr1 : addr0;
          dina_next  = pick ? wdata1 : wdata0;
          cea_next   = 1'b1;
          clka_next  = 1'b0;
          cnt_next   = '0;
          state_next = SETUP;
        end
      end
      SETUP: begin
        // Address/data have had one full cycle of setup; raise clka.
        clka_next  = 1'b1;
        state_next = HIGH;
      end
      HIGH: begin
        if (half_done) begin
          clka_next  = 1'b0;
          cea_next   = 1'b0;
          wrea_next  = 1'b0;
          cnt_next   = '0;
          state_next = LOW;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      LOW: begin
        if (half_done) begin
          cnt_next   = '0;
          state_next = ACK;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      ACK: begin
        last_next  = grant_reg;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Per-requester ack pulse and held read data.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_req
      logic              ack_q;
      logic [DATA_W-1:0] rdata_q;
      always_ff @(posedge sysclk or posedge external_reset) begin
        if (external_reset) begin
          ack_q   <= 1'b0;
          rdata_q <= '0;
        end else begin
          ack_q <= capture && (grant_reg == 1'(gi));
          if (capture && !we_reg && (grant_reg == 1'(gi))) begin
            rdata_q <= mem_douta;
          end
        end
      end
    end
  endgenerate

  assign ack0       = g_req[0].ack_q;
  assign ack1       = g_req[1].ack_q;
  assign rdata0     = g_req[0].rdata_q;
  assign rdata1     = g_req[1].rdata_q;
  assign busy       = (state_reg != IDLE);
  assign mem_clka   = clka_reg;
  assign mem_cea    = cea_reg;
  assign mem_ocea   = cea_reg;
  assign mem_wrea   = wrea_reg;
  assign mem_reseta = 1'b0;
  assign mem_ada    = ada_reg;
  assign mem_dina   = dina_reg;

endmodule
